// File: rtl/adder_checker.sv
`default_nettype none
// ============================================================================
// Module   : adder_checker
// Purpose  : Two-stage response checker for the datapath Adder. It recomputes
//            each sum modulo 2^WIDTH and keeps saturating check/error counts,
//            a sticky IDLE/PASS/FAIL status and an optional first-error capture.
// Config   : define ADDER_CHECKER_CAPTURE_EN to build the first-error capture;
//            when it is undefined, first_err_* and first_err_valid are tied to 0.
// Revision : 1.0  initial release
// ============================================================================
module adder_checker #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [WIDTH-1:0]     in_result,
  input  logic                 clear,
  output logic [CNT_WIDTH-1:0] check_count,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic [1:0]           status,
  output logic                 first_err_valid,
  output logic [WIDTH-1:0]     first_err_a,
  output logic [WIDTH-1:0]     first_err_b,
  output logic [WIDTH-1:0]     first_err_result,
  output logic [WIDTH-1:0]     first_err_expected
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PASS = 2'b01,
    ST_FAIL = 2'b10
  } state_t;

  localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = '1;

  logic                 r_s1_valid;
  logic [WIDTH-1:0]     r_s1_a;
  logic [WIDTH-1:0]     r_s1_b;
  logic [WIDTH-1:0]     r_s1_result;
  logic [WIDTH-1:0]     r_s1_expected;
  logic [CNT_WIDTH-1:0] r_check_count;
  logic [CNT_WIDTH-1:0] r_err_count;
  state_t               r_state;
  logic                 w_mismatch;

  // A mismatch is only meaningful while a sampled vector sits in stage 1.
  assign w_mismatch = r_s1_valid && (r_s1_result != r_s1_expected);

  // Stage 1: sample the vector and precompute the wrapped expected sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid    <= 1'b0;
      r_s1_a        <= '0;
      r_s1_b        <= '0;
      r_s1_result   <= '0;
      r_s1_expected <= '0;
    end else if (clear) begin
      // Drops both the vector in flight and the one presented alongside clear.
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_a        <= in_a;
        r_s1_b        <= in_b;
        r_s1_result   <= in_result;
        r_s1_expected <= in_a + in_b;
      end
    end
  end

  // Stage 2: saturating check and error counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_check_count <= '0;
      r_err_count   <= '0;
    end else if (clear) begin
      r_check_count <= '0;
      r_err_count   <= '0;
    end else if (r_s1_valid) begin
      if (r_check_count != C_CNT_MAX) begin
        r_check_count <= r_check_count + 1'b1;
      end
      if (w_mismatch && (r_err_count != C_CNT_MAX)) begin
        r_err_count <= r_err_count + 1'b1;
      end
    end
  end

  // Status FSM: first good check moves to PASS, any mismatch latches FAIL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else if (clear) begin
      r_state <= ST_IDLE;
    end else if (r_s1_valid) begin
      case (r_state)
        ST_IDLE: r_state <= w_mismatch ? ST_FAIL : ST_PASS;
        ST_PASS: r_state <= w_mismatch ? ST_FAIL : ST_PASS;
        ST_FAIL: r_state <= ST_FAIL;
        default: r_state <= ST_FAIL;
      endcase
    end
  end

  assign check_count = r_check_count;
  assign err_count   = r_err_count;
  assign status      = r_state;

`ifdef ADDER_CHECKER_CAPTURE_EN
  logic             r_cap_valid;
  logic [WIDTH-1:0] r_cap_a;
  logic [WIDTH-1:0] r_cap_b;
  logic [WIDTH-1:0] r_cap_result;
  logic [WIDTH-1:0] r_cap_expected;

  // First-error capture: loads once, held until rst or clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cap_valid    <= 1'b0;
      r_cap_a        <= '0;
      r_cap_b        <= '0;
      r_cap_result   <= '0;
      r_cap_expected <= '0;
    end else if (clear) begin
      r_cap_valid    <= 1'b0;
      r_cap_a        <= '0;
      r_cap_b        <= '0;
      r_cap_result   <= '0;
      r_cap_expected <= '0;
    end else if (w_mismatch && !r_cap_valid) begin
      r_cap_valid    <= 1'b1;
      r_cap_a        <= r_s1_a;
      r_cap_b        <= r_s1_b;
      r_cap_result   <= r_s1_result;
      r_cap_expected <= r_s1_expected;
    end
  end

  assign first_err_valid    = r_cap_valid;
  assign first_err_a        = r_cap_a;
  assign first_err_b        = r_cap_b;
  assign first_err_result   = r_cap_result;
  assign first_err_expected = r_cap_expected;
`else
  assign first_err_valid    = 1'b0;
  assign first_err_a        = '0;
  assign first_err_b        = '0;
  assign first_err_result   = '0;
  assign first_err_expected = '0;
`endif

endmodule
`default_nettype wire
